// File: rtl/pipe_seq_ctrl_pkg.sv
// +----------------------------------------------------------------------------+
// | pipe_seq_ctrl_pkg: state encoding and default timing for pipe_seq_ctrl.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

package pipe_seq_ctrl_pkg;

  localparam logic [1:0] S_RUN      = 2'd0;
  localparam logic [1:0] S_MEM_WAIT = 2'd1;
  localparam logic [1:0] S_DRAIN    = 2'd2;
  localparam logic [1:0] S_HALT     = 2'd3;

  localparam int C_MEM_TIMEOUT_DEFAULT  = 64;
  localparam int C_DRAIN_CYCLES_DEFAULT = 3;

endpackage

`default_nettype wire

// File: rtl/pipe_seq_ctrl_sat_counter.sv
// +----------------------------------------------------------------------------+
// | sat_counter: saturating up-counter with synchronous clear.                 |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (inc && (r_count != '1)) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/pipe_seq_ctrl.sv
// +----------------------------------------------------------------------------+
// | pipe_seq_ctrl: pipeline enable/flush/bubble sequencing with memory freeze, |
// | halt drain, memory timeout and stall/flush performance counters.           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module pipe_seq_ctrl
  import pipe_seq_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT  = C_MEM_TIMEOUT_DEFAULT,
  parameter int DRAIN_CYCLES = C_DRAIN_CYCLES_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ID_br_hazard_stall,
  input  logic        ID_br_ctrl,
  input  logic        ID_load_use,
  input  logic        ID_halt,
  input  logic        M_dmem_req,
  input  logic        M_dmem_ack,
  output logic        PC_en,
  output logic        IFID_en,
  output logic        EXM_en,
  output logic        MWB_en,
  output logic        IFID_flush,
  output logic        IDEX_bubble,
  output logic        halted,
  output logic        mem_timeout_err,
  output logic [31:0] stall_cycles,
  output logic [15:0] flush_count
);

  localparam int C_WAIT_W  = $clog2(MEM_TIMEOUT);
  localparam int C_DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  logic [1:0]           r_state;
  logic [1:0]           w_state_nxt;
  logic [C_WAIT_W-1:0]  r_wait_cnt;
  logic [C_DRAIN_W-1:0] r_drain_cnt;
  logic                 r_ret_drain;
  logic                 r_timeout_err;

  logic w_ack_ret;
  logic w_run_like;
  logic w_drain_like;
  logic w_freeze;
  logic w_hazard;
  logic w_stall;
  logic w_halt_dec;
  logic w_flush;
  logic w_timeout;

  // The ack cycle out of MEM_WAIT behaves like the state the freeze came from.
  assign w_ack_ret    = (r_state == S_MEM_WAIT) && M_dmem_ack;
  assign w_run_like   = (r_state == S_RUN)   || (w_ack_ret && !r_ret_drain);
  assign w_drain_like = (r_state == S_DRAIN) || (w_ack_ret &&  r_ret_drain);

  assign w_freeze   = (((r_state == S_RUN) || (r_state == S_DRAIN)) && M_dmem_req && !M_dmem_ack)
                    || ((r_state == S_MEM_WAIT) && !M_dmem_ack);
  assign w_hazard   = ID_br_hazard_stall || ID_load_use;
  assign w_stall    = !w_freeze && w_run_like && w_hazard;
  assign w_halt_dec = !w_freeze && w_run_like && !w_hazard && ID_halt;
  assign w_flush    = !w_freeze && w_run_like && !w_hazard && !ID_halt && ID_br_ctrl;
  assign w_timeout  = (r_state == S_MEM_WAIT) && !M_dmem_ack
                    && (r_wait_cnt == C_WAIT_W'(MEM_TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= S_RUN;
      r_wait_cnt    <= '0;
      r_drain_cnt   <= '0;
      r_ret_drain   <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      // wait_cnt counts every frozen cycle, including the one that entered MEM_WAIT.
      if (w_freeze) begin
        r_wait_cnt <= (r_state == S_MEM_WAIT) ? r_wait_cnt + C_WAIT_W'(1) : C_WAIT_W'(1);
      end
      if (w_freeze && (r_state != S_MEM_WAIT)) begin
        r_ret_drain <= (r_state == S_DRAIN);
      end
      if (w_halt_dec) begin
        r_drain_cnt <= C_DRAIN_W'(DRAIN_CYCLES - 1);
      end else if ((r_state == S_DRAIN) && !w_freeze && (r_drain_cnt != '0)) begin
        r_drain_cnt <= r_drain_cnt - C_DRAIN_W'(1);
      end
      if (w_timeout) begin
        r_timeout_err <= 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_RUN: begin
        if (w_freeze)        w_state_nxt = S_MEM_WAIT;
        else if (w_halt_dec) w_state_nxt = S_DRAIN;
      end
      S_MEM_WAIT: begin
        if (M_dmem_ack)      w_state_nxt = (r_ret_drain || w_halt_dec) ? S_DRAIN : S_RUN;
        else if (w_timeout)  w_state_nxt = S_HALT;
      end
      S_DRAIN: begin
        if (w_freeze)                w_state_nxt = S_MEM_WAIT;
        else if (r_drain_cnt == '0)  w_state_nxt = S_HALT;
      end
      default: w_state_nxt = S_HALT;
    endcase
  end

  always_comb begin
    PC_en       = 1'b0;
    IFID_en     = 1'b0;
    EXM_en      = 1'b0;
    MWB_en      = 1'b0;
    IFID_flush  = 1'b0;
    IDEX_bubble = 1'b0;
    halted      = (r_state == S_HALT);
    if (!w_freeze && (r_state != S_HALT)) begin
      EXM_en = 1'b1;
      MWB_en = 1'b1;
      if (w_drain_like || w_stall) begin
        IDEX_bubble = 1'b1;
      end else if (w_halt_dec) begin
        IFID_en    = 1'b1;
        IFID_flush = 1'b1;
      end else begin
        PC_en      = 1'b1;
        IFID_en    = 1'b1;
        IFID_flush = w_flush;
      end
    end
  end

  assign mem_timeout_err = r_timeout_err;

  sat_counter #(.WIDTH(32)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (1'b0),
    .inc   (!PC_en && (r_state != S_HALT)),
    .count (stall_cycles)
  );

  sat_counter #(.WIDTH(16)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (1'b0),
    .inc   (w_flush),
    .count (flush_count)
  );

endmodule

`default_nettype wire

// File: tb/tb_pipe_seq_ctrl.sv
// +----------------------------------------------------------------------------+
// | tb_pipe_seq_ctrl: directed vector bench for pipe_seq_ctrl.                 |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module tb_pipe_seq_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        ID_br_hazard_stall = 1'b0;
  logic        ID_br_ctrl = 1'b0;
  logic        ID_load_use = 1'b0;
  logic        ID_halt = 1'b0;
  logic        M_dmem_req = 1'b0;
  logic        M_dmem_ack = 1'b0;
  logic        PC_en, IFID_en, EXM_en, MWB_en, IFID_flush, IDEX_bubble, halted;
  logic        mem_timeout_err;
  logic [31:0] stall_cycles;
  logic [15:0] flush_count;

  int n_checks = 0;
  int n_errors = 0;

  // Input vector bits: {hazard, br_ctrl, load_use, halt, req, ack}
  // Output bits: {PC, IFID, EXM, MWB, flush, bubble, halted}
  typedef struct {
    logic [5:0] in;
    logic [5:0] exp;
  } vec_t;

  localparam logic [5:0] C_IDLE = 6'b000000;
  localparam logic [6:0] C_RUN  = 7'b1111000;
  localparam logic [6:0] C_FRZ  = 7'b0000000;
  localparam logic [6:0] C_DRN  = 7'b0011010;
  localparam logic [6:0] C_HLT  = 7'b0000001;

  pipe_seq_ctrl #(.MEM_TIMEOUT(4), .DRAIN_CYCLES(3)) dut (
    .clk                (clk),
    .reset              (reset),
    .ID_br_hazard_stall (ID_br_hazard_stall),
    .ID_br_ctrl         (ID_br_ctrl),
    .ID_load_use        (ID_load_use),
    .ID_halt            (ID_halt),
    .M_dmem_req         (M_dmem_req),
    .M_dmem_ack         (M_dmem_ack),
    .PC_en              (PC_en),
    .IFID_en            (IFID_en),
    .EXM_en             (EXM_en),
    .MWB_en             (MWB_en),
    .IFID_flush         (IFID_flush),
    .IDEX_bubble        (IDEX_bubble),
    .halted             (halted),
    .mem_timeout_err    (mem_timeout_err),
    .stall_cycles       (stall_cycles),
    .flush_count        (flush_count)
  );

  always #5 clk = ~clk;

  logic [6:0] w_outs;
  assign w_outs = {PC_en, IFID_en, EXM_en, MWB_en, IFID_flush, IDEX_bubble, halted};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [5:0] v);
    {ID_br_hazard_stall, ID_br_ctrl, ID_load_use, ID_halt, M_dmem_req, M_dmem_ack} = v;
  endtask

  task automatic step(input logic [5:0] v, input logic [6:0] exp, input string nm);
    @(negedge clk);
    drive(v);
    #1;
    chk(nm, 32'(w_outs), 32'(exp));
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    drive(C_IDLE);
    @(negedge clk);
    reset = 1'b1;
  endtask

  vec_t tbl[10];
  int   exp_stall;
  int   exp_flush;

  initial begin
    tbl[0] = '{in: 6'b000000, exp: 6'b111100};
    tbl[1] = '{in: 6'b100000, exp: 6'b001101};
    tbl[2] = '{in: 6'b001000, exp: 6'b001101};
    tbl[3] = '{in: 6'b010000, exp: 6'b111110};
    tbl[4] = '{in: 6'b110000, exp: 6'b001101};
    tbl[5] = '{in: 6'b001100, exp: 6'b001101};
    tbl[6] = '{in: 6'b000011, exp: 6'b111100};
    tbl[7] = '{in: 6'b010011, exp: 6'b111110};
    tbl[8] = '{in: 6'b000001, exp: 6'b111100};
    tbl[9] = '{in: 6'b100011, exp: 6'b001101};

    // Reset state
    do_reset();
    #1;
    chk("reset_outs", 32'(w_outs), 32'(C_RUN));
    chk("reset_stall_cnt", stall_cycles, 0);
    chk("reset_flush_cnt", 32'(flush_count), 0);
    chk("reset_err", 32'(mem_timeout_err), 0);

    // Single-cycle RUN behaviour table
    exp_stall = 0;
    exp_flush = 0;
    for (int i = 0; i < 10; i++) begin
      step(tbl[i].in, {tbl[i].exp, 1'b0}, $sformatf("table_%0d", i));
      if (!tbl[i].exp[5]) exp_stall++;
      if (tbl[i].exp[1])  exp_flush++;
    end
    step(C_IDLE, C_RUN, "table_tail_idle");
    chk("table_stall_cnt", stall_cycles, 32'(exp_stall));
    chk("table_flush_cnt", 32'(flush_count), 32'(exp_flush));

    // Hazard held two cycles, then a one-cycle taken branch
    do_reset();
    step(6'b100000, 7'b0011010, "haz_c1");
    step(6'b100000, 7'b0011010, "haz_c2");
    step(C_IDLE, C_RUN, "haz_after");
    chk("haz_stall_cnt", stall_cycles, 2);
    step(6'b010000, 7'b1111100, "br_flush");
    step(C_IDLE, C_RUN, "br_after");
    chk("br_flush_cnt", 32'(flush_count), 1);
    chk("br_stall_cnt", stall_cycles, 2);

    // Memory freeze: ack on the 4th cycle, which is also the timeout cycle
    do_reset();
    step(6'b000010, C_FRZ, "mem_c1");
    step(6'b000010, C_FRZ, "mem_c2");
    step(6'b000010, C_FRZ, "mem_c3");
    step(6'b000011, C_RUN, "mem_ack");
    step(C_IDLE, C_RUN, "mem_back_run");
    chk("mem_stall_cnt", stall_cycles, 3);
    chk("mem_no_err", 32'(mem_timeout_err), 0);

    // Memory timeout
    do_reset();
    for (int i = 0; i < 4; i++) step(6'b000010, C_FRZ, $sformatf("tmo_c%0d", i));
    step(C_IDLE, C_HLT, "tmo_halted");
    chk("tmo_err", 32'(mem_timeout_err), 1);
    step(6'b010011, C_HLT, "tmo_stays_halted");
    step(C_IDLE, C_HLT, "tmo_stays_halted2");
    chk("tmo_stall_cnt", stall_cycles, 4);

    // Halt decode together with taken branch, then drain
    do_reset();
    step(6'b010100, 7'b0111100, "halt_dec");
    step(C_IDLE, C_DRN, "drain_c1");
    step(C_IDLE, C_DRN, "drain_c2");
    step(C_IDLE, C_DRN, "drain_c3");
    step(C_IDLE, C_HLT, "drain_halted");
    chk("halt_flush_cnt", 32'(flush_count), 0);
    chk("halt_stall_cnt", stall_cycles, 4);

    // Drain interrupted by a memory access
    do_reset();
    step(6'b000100, 7'b0111100, "hd2_dec");
    step(C_IDLE, C_DRN, "hd2_drain_c1");
    step(6'b000010, C_FRZ, "hd2_frz_c1");
    step(6'b000010, C_FRZ, "hd2_frz_c2");
    step(6'b000011, C_DRN, "hd2_ack");
    step(C_IDLE, C_DRN, "hd2_drain_c2");
    step(C_IDLE, C_DRN, "hd2_drain_c3");
    step(C_IDLE, C_HLT, "hd2_halted");
    chk("hd2_stall_cnt", stall_cycles, 7);
    chk("hd2_no_err", 32'(mem_timeout_err), 0);

    // Asynchronous reset in the middle of MEM_WAIT
    do_reset();
    step(6'b000010, C_FRZ, "rst_frz_c1");
    step(6'b000010, C_FRZ, "rst_frz_c2");
    @(negedge clk);
    #2;
    reset = 1'b0;
    drive(C_IDLE);
    #1;
    chk("rst_mid_outs", 32'(w_outs), 32'(C_RUN));
    chk("rst_mid_stall_cnt", stall_cycles, 0);
    @(negedge clk);
    reset = 1'b1;
    step(C_IDLE, C_RUN, "rst_mid_run");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
